rom_arbiter: RTL and testbench

- Shares one synchronous sprite/tile ROM (1-cycle read latency, registered data_out) between NREQ independent requesters, such as sprite renderers and a text overlay.
- Each cycle it picks at most one requester round-robin and drives that requester's address to the ROM.
- One cycle later it returns the ROM word tagged with the winner's ID.
- Optional per-requester lock allows short bursts (one sprite row), capped by MAX_BURST to guarantee fairness.

---
 rtl/rom_arbiter.sv | 112 +++++++++++
 tb/tb_rom_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Round-robin arbiter sharing one 1-cycle-latency ROM between
//               NREQ requesters, with capped burst locking and tagged returns.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDRW     = 8,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    localparam int c_IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDRW-1:0]  req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDRW-1:0]       rom_addr,
    input  logic [WIDTH-1:0]       rom_data,
    output logic [NREQ-1:0]        rd_valid,
    output logic [c_IDW-1:0]       rd_id,
    output logic [WIDTH-1:0]       rd_data
);

    localparam int                c_BCW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BCW-1:0]  c_BURST_LAST = c_BCW'(MAX_BURST - 1);
    localparam bit                c_LOCK_EN    = (MAX_BURST > 1);

    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] r_owner;
    logic [c_BCW-1:0] r_burst_cnt;
    logic             r_locked;
    logic [ADDRW-1:0] r_last_addr;
    logic [NREQ-1:0]  r_rd_valid;
    logic [c_IDW-1:0] r_rd_id;

    logic             w_rr_found;
    logic [c_IDW-1:0] w_rr_winner;
    logic             w_lock_hold;
    logic [c_IDW-1:0] w_winner;
    logic             w_grant;

    function automatic logic [c_IDW-1:0] f_wrap(input int v);
        return c_IDW'((v >= NREQ) ? (v - NREQ) : v);
    endfunction

    // Round-robin scan starting at r_ptr
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_rr_found && req[f_wrap(int'(r_ptr) + k)]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = f_wrap(int'(r_ptr) + k);
            end
        end
    end

    // Owner keeps the ROM only while it still asks, still locks and is under the cap
    assign w_lock_hold = r_locked && req[r_owner] && req_lock[r_owner] &&
                         (r_burst_cnt < c_BURST_LAST);
    assign w_winner    = w_lock_hold ? r_owner : w_rr_winner;
    assign w_grant     = !reset && w_rr_found;

    always_comb begin
        gnt = '0;
        if (w_grant) begin
            gnt[w_winner] = 1'b1;
        end
    end

    // Idle cycles replay the last address so the ROM input stays quiet
    assign rom_addr = w_grant ? req_addr[w_winner*ADDRW +: ADDRW] : r_last_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_locked    <= 1'b0;
            r_last_addr <= '0;
            r_rd_valid  <= '0;
            r_rd_id     <= '0;
        end else begin
            r_rd_valid <= gnt;
            if (w_grant) begin
                r_last_addr <= rom_addr;
                r_ptr       <= f_wrap(int'(w_winner) + 1);
                r_rd_id     <= w_winner;
                r_locked    <= req_lock[w_winner] && c_LOCK_EN;
                if (w_lock_hold) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end else begin
                    r_owner     <= w_winner;
                    r_burst_cnt <= '0;
                end
            end else begin
                r_locked    <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_id    = r_rd_id;
    assign rd_data  = rom_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Directed self-checking bench for rom_arbiter with a ROM model
//               whose contents are addr ^ 8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

    localparam int NREQ      = 4;
    localparam int ADDRW     = 8;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ-1:0]       gnt;
    logic [ADDRW-1:0]      rom_addr;
    logic [WIDTH-1:0]      rom_data;
    logic [NREQ-1:0]       rd_valid;
    logic [1:0]            rd_id;
    logic [WIDTH-1:0]      rd_data;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_g;
    logic [3:0] prev_g;
    logic [1:0] prev_id;
    logic [7:0] prev_a;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;

    rom_arbiter #(
        .NREQ(NREQ), .ADDRW(ADDRW), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_lock(req_lock),
        .req_addr(req_addr), .gnt(gnt), .rom_addr(rom_addr),
        .rom_data(rom_data), .rd_valid(rd_valid), .rd_id(rd_id),
        .rd_data(rd_data)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL reset_rd_valid got %b exp 0000", rd_valid); end
        checks++; if (rd_id !== 2'd0) begin errors++; $display("FAIL reset_rd_id got %0d exp 0", rd_id); end
        next_cycle();
        reset = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b exp 0000", gnt); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL idle_rom_addr got %h exp 00", rom_addr); end
        next_cycle();
    endtask

    task automatic test_single();
        req = 4'b0001;
        req_addr[7:0] = 8'h10;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
        checks++; if (rom_addr !== 8'h10) begin errors++; $display("FAIL single_rom_addr got %h exp 10", rom_addr); end
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL single_rd_valid got %b exp 0001", rd_valid); end
        checks++; if (rd_id !== 2'd0) begin errors++; $display("FAIL single_rd_id got %0d exp 0", rd_id); end
        checks++; if (rd_data !== 8'hB5) begin errors++; $display("FAIL single_rd_data got %h exp b5", rd_data); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        next_cycle();
        reset    = 1'b0;
        req      = 4'b1111;
        req_addr = {8'h53, 8'h42, 8'h31, 8'h20};
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            @(negedge clk);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, exp_g); end
            checks++; if (rom_addr !== 8'h20 + 8'h11 * 8'(k % 4)) begin errors++; $display("FAIL rr_rom_addr[%0d] got %h", k, rom_addr); end
            if (k > 0) begin
                checks++; if (rd_valid !== prev_g) begin errors++; $display("FAIL rr_rd_valid[%0d] got %b exp %b", k, rd_valid, prev_g); end
                checks++; if (rd_id !== prev_id) begin errors++; $display("FAIL rr_rd_id[%0d] got %0d exp %0d", k, rd_id, prev_id); end
                checks++; if (rd_data !== (prev_a ^ 8'hA5)) begin errors++; $display("FAIL rr_rd_data[%0d] got %h exp %h", k, rd_data, prev_a ^ 8'hA5); end
            end
            prev_g  = exp_g;
            prev_id = 2'(k % 4);
            prev_a  = 8'h20 + 8'h11 * 8'(k % 4);
            next_cycle();
        end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (rd_valid !== 4'b1000) begin errors++; $display("FAIL rr_last_rd_valid got %b exp 1000", rd_valid); end
        checks++; if (rd_id !== 2'd3) begin errors++; $display("FAIL rr_last_rd_id got %0d exp 3", rd_id); end
        checks++; if (rd_data !== (8'h53 ^ 8'hA5)) begin errors++; $display("FAIL rr_last_rd_data got %h exp %h", rd_data, 8'h53 ^ 8'hA5); end
        next_cycle();
        @(negedge clk);
        checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rr_idle_rd_valid got %b exp 0000", rd_valid); end
        next_cycle();
    endtask

    task automatic test_burst();
        req      = 4'b0011;
        req_lock = 4'b0001;
        req_addr = {8'h00, 8'h00, 8'h60, 8'h50};
        for (int k = 0; k < 7; k++) begin
            exp_g = (k == 4) ? 4'b0010 : 4'b0001;
            @(negedge clk);
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL burst_gnt[%0d] got %b exp %b", k, gnt, exp_g); end
            checks++; if (rom_addr !== ((k == 4) ? 8'h60 : 8'h50)) begin errors++; $display("FAIL burst_rom_addr[%0d] got %h", k, rom_addr); end
            if (k > 0) begin
                checks++; if (rd_valid !== prev_g) begin errors++; $display("FAIL burst_rd_valid[%0d] got %b exp %b", k, rd_valid, prev_g); end
            end
            prev_g = exp_g;
            next_cycle();
        end
        req      = 4'b0000;
        req_lock = 4'b0000;
        next_cycle();
    endtask

    task automatic test_lock_single();
        req      = 4'b0100;
        req_lock = 4'b0100;
        req_addr = {8'h00, 8'h70, 8'h00, 8'h00};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_gnt[%0d] got %b exp 0100", k, gnt); end
            if (k > 0) begin
                checks++; if (rd_valid !== 4'b0100) begin errors++; $display("FAIL lock_rd_valid[%0d] got %b exp 0100", k, rd_valid); end
                checks++; if (rd_id !== 2'd2) begin errors++; $display("FAIL lock_rd_id[%0d] got %0d exp 2", k, rd_id); end
                checks++; if (rd_data !== (8'h70 ^ 8'hA5)) begin errors++; $display("FAIL lock_rd_data[%0d] got %h", k, rd_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got %b exp 0000", gnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_rd_valid got %b exp 0000", rd_valid); end
        checks++; if (rd_id !== 2'd0) begin errors++; $display("FAIL rstmid_rd_id got %0d exp 0", rd_id); end
        next_cycle();
        reset    = 1'b0;
        req      = 4'b1111;
        req_lock = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first_gnt got %b exp 0001", gnt); end
        next_cycle();
    endtask

    task automatic test_idle_hold();
        req = 4'b0010;
        req_addr[15:8] = 8'h3C;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL hold_gnt got %b exp 0010", gnt); end
        checks++; if (rom_addr !== 8'h3C) begin errors++; $display("FAIL hold_rom_addr got %h exp 3c", rom_addr); end
        next_cycle();
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_idle_gnt got %b exp 0000", gnt); end
        checks++; if (rom_addr !== 8'h3C) begin errors++; $display("FAIL hold_idle_addr1 got %h exp 3c", rom_addr); end
        checks++; if (rd_valid !== 4'b0010) begin errors++; $display("FAIL hold_rd_valid got %b exp 0010", rd_valid); end
        checks++; if (rd_data !== (8'h3C ^ 8'hA5)) begin errors++; $display("FAIL hold_rd_data got %h exp %h", rd_data, 8'h3C ^ 8'hA5); end
        next_cycle();
        @(negedge clk);
        checks++; if (rom_addr !== 8'h3C) begin errors++; $display("FAIL hold_idle_addr2 got %h exp 3c", rom_addr); end
        checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL hold_idle_rd_valid got %b exp 0000", rd_valid); end
        next_cycle();
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_lock = '0;
        req_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_lock_single();
        test_reset_mid();
        test_idle_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
